// File: rtl/mem_unit_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and data memory.
// The master issues one request at a time and holds it until ack or abort.
interface mem_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_unit.sv
// Tronsistor MEM stage: EX/MEM and MEM/WB registers plus a req/ack data-memory FSM
// that stalls upstream while an access is outstanding and aborts after TIMEOUT cycles.
module mem_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemToReg_in,
    input  logic        MemSrc_in,
    input  logic [4:0]  DestReg_in,
    input  logic [31:0] EX_out,
    input  logic [31:0] MemWrite_data,
    output logic        stall,
    mem_unit_if.master  mem,
    output logic        mem_err,
    output logic        fwd_RegWrite,
    output logic [4:0]  fwd_DestReg,
    output logic [31:0] fwd_data,
    output logic        WB_valid,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_DestReg,
    output logic [31:0] WB_data
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              exm_valid_q, exm_valid_d;
    logic              exm_regwrite_q, exm_regwrite_d;
    logic              exm_memtoreg_q, exm_memtoreg_d;
    logic              exm_mem_q, exm_mem_d;
    logic [4:0]        exm_dest_q, exm_dest_d;
    logic [31:0]       exm_data_q, exm_data_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic [4:0]        wb_dest_q, wb_dest_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic              is_mem;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // MemSrc swaps the operands so stack pushes address through the store-data path.
    assign sel_addr  = MemSrc_in ? MemWrite_data[ADDR_W-1:0] : EX_out[ADDR_W-1:0];
    assign sel_wdata = MemSrc_in ? EX_out : MemWrite_data;
    assign is_mem    = valid_in & (MemRead_in | MemWrite_in);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        exm_valid_d    = exm_valid_q;
        exm_regwrite_d = exm_regwrite_q;
        exm_memtoreg_d = exm_memtoreg_q;
        exm_mem_d      = exm_mem_q;
        exm_dest_d     = exm_dest_q;
        exm_data_d     = exm_data_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        err_d          = err_q;
        wb_valid_d     = 1'b0;
        wb_regwrite_d  = wb_regwrite_q;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;

        case (state_q)
            IDLE: begin
                exm_valid_d    = valid_in;
                exm_regwrite_d = RegWrite_in;
                exm_memtoreg_d = MemToReg_in;
                exm_mem_d      = is_mem;
                exm_dest_d     = DestReg_in;
                exm_data_d     = EX_out;
                // A valid mem op never reaches here: it always leaves via ACCESS.
                if (exm_valid_q && !exm_mem_q) begin
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = exm_regwrite_q;
                    wb_dest_d     = exm_dest_q;
                    wb_data_d     = exm_data_q;
                end
                if (is_mem) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = MemWrite_in;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = exm_regwrite_q;
                    wb_dest_d     = exm_dest_q;
                    wb_data_d     = exm_memtoreg_q ? mem.mem_rdata : exm_data_q;
                    exm_valid_d   = 1'b0;
                    req_d         = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d       = 1'b1;
                    req_d       = 1'b0;
                    exm_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            exm_valid_q    <= 1'b0;
            exm_regwrite_q <= 1'b0;
            exm_memtoreg_q <= 1'b0;
            exm_mem_q      <= 1'b0;
            exm_dest_q     <= '0;
            exm_data_q     <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            stall_q        <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            exm_valid_q    <= exm_valid_d;
            exm_regwrite_q <= exm_regwrite_d;
            exm_memtoreg_q <= exm_memtoreg_d;
            exm_mem_q      <= exm_mem_d;
            exm_dest_q     <= exm_dest_d;
            exm_data_q     <= exm_data_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            err_q          <= err_d;
            stall_q        <= stall_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
        end
    end

    assign stall         = stall_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem_err       = err_q;
    assign fwd_RegWrite  = exm_valid_q & exm_regwrite_q;
    assign fwd_DestReg   = exm_dest_q;
    assign fwd_data      = exm_data_q;
    assign WB_valid      = wb_valid_q;
    assign WB_RegWrite   = wb_regwrite_q;
    assign WB_DestReg    = wb_dest_q;
    assign WB_data       = wb_data_q;
endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: pipelined ALU ops, loads/stores with variable ack
// latency, timeout abort, asynchronous reset mid-access and bubbles.
module tb_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic        RegWrite_in = 1'b0, MemWrite_in = 1'b0, MemRead_in = 1'b0;
    logic        MemToReg_in = 1'b0, MemSrc_in = 1'b0;
    logic [4:0]  DestReg_in = '0;
    logic [31:0] EX_out = '0, MemWrite_data = '0;
    logic        stall, mem_err, fwd_RegWrite, WB_valid, WB_RegWrite;
    logic [4:0]  fwd_DestReg, WB_DestReg;
    logic [31:0] fwd_data, WB_data;

    int checks = 0;
    int failures = 0;

    mem_unit_if #(.ADDR_W(16)) bus ();

    mem_unit #(.ADDR_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .DestReg_in(DestReg_in),
        .EX_out(EX_out), .MemWrite_data(MemWrite_data), .stall(stall), .mem(bus),
        .mem_err(mem_err), .fwd_RegWrite(fwd_RegWrite), .fwd_DestReg(fwd_DestReg),
        .fwd_data(fwd_data), .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite),
        .WB_DestReg(WB_DestReg), .WB_data(WB_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic mw, input logic mr,
                          input logic m2r, input logic ms, input logic [4:0] d,
                          input logic [31:0] ex, input logic [31:0] wd);
        valid_in = v; RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr;
        MemToReg_in = m2r; MemSrc_in = ms; DestReg_in = d; EX_out = ex; MemWrite_data = wd;
    endtask

    task automatic test_reset;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #1 rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_err); end
        checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL reset_wbv got=%b exp=0", WB_valid); end
        checks++; if (WB_data !== 32'h0) begin failures++; $display("FAIL reset_wbdata got=%h exp=0", WB_data); end
        checks++; if (fwd_RegWrite !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", fwd_RegWrite); end
        tick; tick;
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_data;
        for (int t = 1; t <= 5; t++) begin
            if (t <= 3) set_op(1, 1, 0, 0, 0, 0, 5'(t), 32'h11 * t, 32'h0);
            else        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
            tick;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall t=%0d got=%b exp=0", t, stall); end
            if (t == 1) begin
                checks++; if (fwd_RegWrite !== 1'b1 || fwd_DestReg !== 5'd1 || fwd_data !== 32'h11) begin
                    failures++; $display("FAIL b2b_fwd got=%b/%0d/%h exp=1/1/00000011", fwd_RegWrite, fwd_DestReg, fwd_data); end
            end
            if (t >= 2 && t <= 4) begin
                exp_data = 32'h11 * (t - 1);
                checks++; if (WB_valid !== 1'b1 || WB_DestReg !== 5'(t - 1) || WB_data !== exp_data || WB_RegWrite !== 1'b1) begin
                    failures++; $display("FAIL b2b_wb t=%0d got=%b/%0d/%h exp=1/%0d/%h", t, WB_valid, WB_DestReg, WB_data, t - 1, exp_data); end
            end else begin
                checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL b2b_wbv t=%0d got=%b exp=0", t, WB_valid); end
            end
            $display("txn b2b t=%0d WB_valid=%b dest=%0d data=%h", t, WB_valid, WB_DestReg, WB_data);
        end
    endtask

    task automatic test_load;
        int sc = 0;
        set_op(1, 1, 0, 1, 1, 0, 5'd5, 32'h0000_1234, 32'h0000_9999);
        tick;
        set_op(1, 1, 0, 0, 0, 0, 5'd6, 32'h66, 32'h0);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h1234) begin
            failures++; $display("FAIL load_req got=%b/%b/%h exp=1/0/1234", bus.mem_req, bus.mem_we, bus.mem_addr); end
        if (stall) sc++;
        tick; if (stall) sc++;
        tick; if (stall) sc++;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        checks++; if (sc != 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", sc); end
        checks++; if (WB_valid !== 1'b1 || WB_DestReg !== 5'd5 || WB_data !== 32'hDEAD_BEEF || WB_RegWrite !== 1'b1) begin
            failures++; $display("FAIL load_wb got=%b/%0d/%h exp=1/5/deadbeef", WB_valid, WB_DestReg, WB_data); end
        checks++; if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL load_release got=%b/%b exp=0/0", stall, bus.mem_req); end
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL load_bubble got=%b exp=0", WB_valid); end
        tick;
        checks++; if (WB_valid !== 1'b1 || WB_DestReg !== 5'd6 || WB_data !== 32'h66) begin
            failures++; $display("FAIL load_next got=%b/%0d/%h exp=1/6/00000066", WB_valid, WB_DestReg, WB_data); end
        $display("txn load addr=1234 data=deadbeef then dest6");
    endtask

    task automatic test_store;
        set_op(1, 0, 1, 0, 0, 1, 5'd0, 32'hCAFE_0001, 32'h0000_0100);
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 32'hCAFE_0001 || stall !== 1'b1) begin
            failures++; $display("FAIL store_req got=%b/%h/%h/%b exp=1/0100/cafe0001/1", bus.mem_we, bus.mem_addr, bus.mem_wdata, stall); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        checks++; if (WB_valid !== 1'b1 || WB_RegWrite !== 1'b0 || WB_data !== 32'hCAFE_0001) begin
            failures++; $display("FAIL store_wb got=%b/%b/%h exp=1/0/cafe0001", WB_valid, WB_RegWrite, WB_data); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", mem_err); end
        tick;
        $display("txn store addr=0100 wdata=cafe0001");
    endtask

    task automatic test_timeout;
        int req_cnt = 0;
        int wb_seen = 0;
        set_op(1, 1, 0, 1, 1, 0, 5'd7, 32'h0000_0200, 32'h0);
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        if (bus.mem_req) req_cnt++;
        for (int j = 1; j <= 16; j++) begin
            tick;
            if (bus.mem_req) req_cnt++;
            if (WB_valid) wb_seen++;
        end
        checks++; if (req_cnt != 16) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=16", req_cnt); end
        checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", mem_err); end
        checks++; if (wb_seen != 0) begin failures++; $display("FAIL timeout_wb got=%0d exp=0", wb_seen); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL timeout_stall got=%b exp=0", stall); end
        set_op(1, 1, 0, 0, 0, 0, 5'd8, 32'h88, 32'h0);
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        checks++; if (WB_valid !== 1'b1 || WB_DestReg !== 5'd8 || WB_data !== 32'h88) begin
            failures++; $display("FAIL timeout_resume got=%b/%0d/%h exp=1/8/00000088", WB_valid, WB_DestReg, WB_data); end
        checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky got=%b exp=1", mem_err); end
        $display("txn timeout req_cycles=%0d err=%b", req_cnt, mem_err);
    endtask

    task automatic test_reset_mid;
        set_op(1, 1, 1, 1, 0, 0, 5'd10, 32'h0000_0300, 32'h55);
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1) begin
            failures++; $display("FAIL rw_is_write got=%b/%b exp=1/1", bus.mem_we, bus.mem_req); end
        tick; tick;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got=%b/%b/%b exp=0/0/0", bus.mem_req, stall, mem_err); end
        checks++; if (WB_valid !== 1'b0 || WB_RegWrite !== 1'b0 || WB_DestReg !== 5'd0 || WB_data !== 32'h0) begin
            failures++; $display("FAIL midrst_wb got=%b/%b/%0d/%h exp=0/0/0/0", WB_valid, WB_RegWrite, WB_DestReg, WB_data); end
        checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0 || bus.mem_we !== 1'b0) begin
            failures++; $display("FAIL midrst_bus got=%h/%h/%b exp=0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
        tick;
        rst = 1'b0;
        set_op(1, 1, 0, 0, 0, 0, 5'd9, 32'h99, 32'h0);
        tick;
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        checks++; if (WB_valid !== 1'b1 || WB_DestReg !== 5'd9 || WB_data !== 32'h99 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL midrst_resume got=%b/%0d/%h/%b exp=1/9/00000099/0", WB_valid, WB_DestReg, WB_data, bus.mem_req); end
        $display("txn reset mid-access then dest9");
    endtask

    task automatic test_bubble;
        set_op(0, 1, 0, 1, 1, 0, 5'd3, 32'h0000_0400, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick;
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL bubble_req got=%b/%b exp=0/0", bus.mem_req, stall); end
        checks++; if (fwd_RegWrite !== 1'b0) begin failures++; $display("FAIL bubble_fwd got=%b exp=0", fwd_RegWrite); end
        tick;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL bubble_wb got=%b exp=0", WB_valid); end
        $display("txn bubble");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load;
        test_store;
        test_timeout;
        test_reset_mid;
        test_bubble;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_unit.md
# mem_unit

Memory stage of the Tronsistor CPU pipeline. It sits directly downstream of EX_Unit and consumes its RegWrite/MemWrite/MemRead/MemToReg/MemSrc/DestReg/EX_out/MemWrite_data outputs. It contains the EX/MEM and MEM/WB pipeline registers and a request/acknowledge data-memory handshake FSM with timeout. While a memory access is outstanding it stalls everything upstream.

## Interface

Parameters:
- ADDR_W, 16: data-memory address width; mem_addr is the low ADDR_W bits of the selected 32-bit address.
- TIMEOUT, 16: maximum number of ACCESS cycles without mem_ack before the access is aborted (≥2).

Ports:
- clk  in  1  pipeline clock (one clock domain)
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  EX output carries a real instruction (0 = bubble)
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in  in  1 each  control from EX_Unit
- DestReg_in  in  5  destination register
- EX_out  in  32  ALU result
- MemWrite_data  in  32  store operand
- stall  out  1  upstream must hold IF/ID/EX state this cycle
- mem_req, mem_we  out  1  memory request and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  memory completes the access at this edge
- mem_err  out  1  sticky timeout flag
- fwd_RegWrite, fwd_DestReg[4:0], fwd_data[31:0]  out  EX/MEM contents for forwarding; fwd_RegWrite is gated by EX/MEM valid
- WB_valid, WB_RegWrite  out  1  writeback qualifiers
- WB_DestReg  out  5  writeback register
- WB_data  out  32  writeback value

## Operation

- Address/data select, evaluated at capture:
  - MemSrc=0: addr = EX_out, wdata = MemWrite_data.
  - MemSrc=1: addr = MemWrite_data, wdata = EX_out (stack push/call).
- A mem op is valid_in & (MemRead_in | MemWrite_in). If both MemRead_in and MemWrite_in are set, the access is a write.
- FSM states are IDLE and ACCESS.
- IDLE, every rising edge:
  - EX/MEM captures the inputs; its valid bit = valid_in.
  - If the captured instruction is a mem op: state←ACCESS, mem_req←1, mem_we/mem_addr/mem_wdata latched, timeout counter←0.
  - If EX/MEM held a valid non-mem op before the edge, MEM/WB loads it: WB_valid=1, WB_data=EX_out. Otherwise WB_valid←0.
- ACCESS:
  - stall=1; EX/MEM holds its contents; mem_req/we/addr/wdata stay stable.
  - Edge with mem_ack=1:
    - MEM/WB loads: WB_valid=1, WB_RegWrite=RegWrite, WB_data = MemToReg ? mem_rdata : EX_out.
    - EX/MEM valid←0, mem_req←0, state←IDLE.
  - Edge with mem_ack=0 and counter==TIMEOUT-1:
    - Abort: mem_err←1, mem_req←0, EX/MEM valid←0, WB_valid←0, state←IDLE.
  - Otherwise counter increments and WB_valid←0.
- stall = (state==ACCESS). It is a registered decode, so there is no combinational path from mem_ack.
- mem_ack while in IDLE is ignored.
- mem_err is cleared only by rst.
- Reset (asynchronous, any time, including mid-access):
  - state=IDLE, all valid bits=0, all outputs 0 (stall, mem_req, mem_we, mem_addr, mem_wdata, mem_err, fwd_*, WB_*).
  - An in-flight request is dropped immediately.

## Timing

- Non-mem op presented with stall=0 before edge k: captured at k, WB_valid=1 after k+1.
- Mem op captured at edge k: mem_req high from after k. With ack sampled at edge k+n (n≥1), WB_valid=1 for the cycle after k+n; stall is high for cycles k..k+n-1 after the edges.
- A single-cycle ack (n=1) gives the same WB latency as a non-mem op.
- After a mem op completes there is exactly one WB_valid=0 cycle before the held upstream instruction appears.
- Timeout abort at edge k+TIMEOUT; mem_req is high for exactly TIMEOUT cycles.
- Back-to-back non-mem ops sustain one WB_valid per cycle.

## Test plan

- Reset, then three back-to-back ADD-type ops (RegWrite=1, DestReg=1,2,3, EX_out=0x11,0x22,0x33) → WB on consecutive cycles with matching DestReg/WB_data; stall never asserted.
- Load, MemSrc=0, EX_out=0x0000_1234, memory acks after 3 cycles with rdata=0xDEADBEEF → mem_addr=0x1234, mem_we=0, stall high 3 cycles, WB_data=0xDEADBEEF, following op written back one bubble later.
- Store, MemSrc=1, MemWrite_data=0x0100, EX_out=0xCAFE0001, ack after 1 cycle → mem_addr=0x0100, mem_wdata=0xCAFE0001, mem_we=1, WB_RegWrite=0.
- Load with mem_ack never asserted, TIMEOUT=16 → mem_req high exactly 16 cycles, mem_err=1 and stays 1, no WB_valid for that op, pipeline resumes.
- rst asserted two cycles into an ACCESS → mem_req, stall, and all WB_* outputs 0 immediately without waiting for a clock edge; next op after release behaves normally.
- Bubble (valid_in=0 with MemRead_in=1) → no mem_req, WB_valid=0, fwd_RegWrite=0.
